// File: rtl/accum_drain_if.sv
// ---------------------------------------------------------------------------
// accum_drain_if
//
// Bundles the two data-path links of the column drain engine:
//   - the accumulator column port: read enable/address out, read data back
//     one cycle later, plus the whole-column clear pulse;
//   - the processed-element stream toward the output buffer (valid/ready
//     with a last marker).
//
// Modports:
//   master : the drain engine (drives reads, clear and the output stream)
//   slave  : the surrounding fabric (column storage + output buffer)
//
// Signals:
//   col_rd_en    master->slave  column read enable
//   col_rd_addr  master->slave  column read address (ADDR_W)
//   col_rd_data  slave->master  signed read data, valid the cycle after col_rd_en
//   col_clear    master->slave  one-cycle pulse clearing the whole column
//   out_valid    master->slave  out_data / out_last are valid
//   out_ready    slave->master  downstream accepts the current element
//   out_data     master->slave  signed processed element (OUT_WIDTH)
//   out_last     master->slave  final element of the drain (qualified by out_valid)
// ---------------------------------------------------------------------------
interface accum_drain_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_W     = 10
);

  logic                         col_rd_en;
  logic [ADDR_W-1:0]            col_rd_addr;
  logic signed [DATA_WIDTH-1:0] col_rd_data;
  logic                         col_clear;

  logic                         out_valid;
  logic                         out_ready;
  logic signed [OUT_WIDTH-1:0]  out_data;
  logic                         out_last;

  modport master (
    output col_rd_en,
    output col_rd_addr,
    input  col_rd_data,
    output col_clear,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  col_rd_en,
    input  col_rd_addr,
    output col_rd_data,
    input  col_clear,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );

endinterface : accum_drain_if

// File: rtl/accum_drain.sv
// ---------------------------------------------------------------------------
// accum_drain
//
// Drains one accumulator column after a tile finishes accumulating. Entries
// 0..num_rows-1 are read in ascending order through the column's 1-cycle
// read port, each one is arithmetic-right-shifted, optionally ReLU-clamped
// and saturated to OUT_WIDTH, then streamed out over valid/ready. When the
// last element has been accepted the column is cleared with a single pulse
// and `done` pulses for one cycle.
//
// Ports:
//   clk       clock, all state changes on its rising edge
//   rst_n     asynchronous active-low reset (abandons any drain, no clear)
//   start     one-cycle pulse starting a drain, honoured only while idle
//   num_rows  entries to drain (ADDR_W+1 bits), clamped to NUM_ACCUM_ROWS
//   shift     arithmetic right-shift amount, sampled on start
//   relu_en   clamp negative results to zero, sampled on start
//   busy      high in every state except IDLE
//   done      one-cycle pulse once drain and clear are complete
//   bus       accum_drain_if.master: column read port, column clear and
//             the processed-element output stream
// ---------------------------------------------------------------------------
module accum_drain #(
  parameter int  DATA_WIDTH     = 8,
  parameter int  OUT_WIDTH      = 8,
  parameter int  MAX_OUT_ROWS   = 128,
  parameter int  MAX_OUT_COLS   = 128,
  parameter int  SYS_ARR_COLS   = 16,
  localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS),
  localparam int ADDR_W         = $clog2(NUM_ACCUM_ROWS),
  localparam int SH_W           = $clog2(DATA_WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_rows,
  input  logic [SH_W-1:0]   shift,
  input  logic              relu_en,
  output logic              busy,
  output logic              done,
  accum_drain_if.master     bus
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam logic [ADDR_W:0] ROWS_CAP = (ADDR_W + 1)'(NUM_ACCUM_ROWS);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  // Saturation bounds expressed at the accumulator width so the comparison
  // against the shifted value is a plain signed compare.
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX =
    DATA_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN =
    DATA_WIDTH'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  typedef enum logic [2:0] {
    IDLE,
    READ,
    FLUSH,
    CLEAR,
    DONE
  } state_e;

  // One FIFO slot: post-processed element plus its end-of-drain marker.
  typedef struct packed {
    logic                        last;
    logic signed [OUT_WIDTH-1:0] data;
  } elem_t;

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  state_e                       state, state_nxt;

  logic [ADDR_W:0]              rows_q;         // clamped row count of this drain
  logic [SH_W-1:0]              shift_q;
  logic                         relu_q;
  logic [ADDR_W:0]              rows_clamped;

  // ADDR_W+1 bits so a full-column drain reaches the top address and the
  // terminal count without aliasing back to zero.
  logic [ADDR_W:0]              rd_cnt;
  logic                         inflight;       // read issued last cycle, data arriving now
  logic                         inflight_last;  // ...and it is the final entry

  elem_t                        fifo_mem [2];
  logic                         wr_ptr;
  logic                         rd_ptr;
  logic [1:0]                   fifo_cnt;

  logic                         accept;         // start honoured this cycle
  logic                         push;
  logic                         pop;
  logic                         rd_en;
  logic                         clear;
  logic                         last_issue;
  logic                         can_issue;
  logic [2:0]                   occupancy;

  logic signed [DATA_WIDTH-1:0] shifted;
  logic signed [DATA_WIDTH-1:0] rectified;
  elem_t                        proc;

  // -------------------------------------------------------------------------
  // Start acceptance and configuration capture
  // -------------------------------------------------------------------------
  assign accept       = (state == IDLE) && start;
  assign rows_clamped = (num_rows > ROWS_CAP) ? ROWS_CAP : num_rows;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of the order the blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else if (accept) begin
      rows_q  <= rows_clamped;
      shift_q <= shift;
      relu_q  <= relu_en;
    end
  end

  // -------------------------------------------------------------------------
  // Read issue
  //
  // The FIFO has two slots, so at most two elements may be owed to the
  // downstream at any time (buffered plus in flight). A pop happening this
  // same cycle frees its slot at the edge, so it is credited immediately;
  // without that credit a continuously-ready consumer would only see two
  // elements every three cycles.
  // -------------------------------------------------------------------------
  assign pop        = bus.out_valid && bus.out_ready;
  assign push       = inflight;
  assign occupancy  = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign can_issue  = (occupancy < 3'd2);
  assign last_issue = (rd_cnt == (rows_q - CNT_ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      if (accept) begin
        rd_cnt <= '0;
      end else if (rd_en) begin
        rd_cnt <= rd_cnt + CNT_ONE;
      end
      inflight      <= rd_en;
      inflight_last <= rd_en && last_issue;
    end
  end

  // -------------------------------------------------------------------------
  // Post-processing of the returning read data (before the FIFO push)
  // -------------------------------------------------------------------------
  always_comb begin
    shifted   = $signed(bus.col_rd_data) >>> shift_q;
    rectified = (relu_q && shifted[DATA_WIDTH-1]) ? '0 : shifted;

    proc.last = inflight_last;
    if (rectified > SAT_MAX) begin
      proc.data = SAT_MAX[OUT_WIDTH-1:0];
    end else if (rectified < SAT_MIN) begin
      proc.data = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      proc.data = rectified[OUT_WIDTH-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // Two-entry output FIFO (push and pop may coincide)
  // -------------------------------------------------------------------------
  // NOTE: the storage slots are reset as well, so out_data reads zero after
  // reset instead of whatever the flops powered up with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= proc;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    clear     = 1'b0;
    done      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (rows_clamped == '0) ? CLEAR : READ;
        end
      end

      READ: begin
        rd_en = can_issue;
        if (can_issue && last_issue) begin
          state_nxt = FLUSH;
        end
      end

      // Empty FIFO with nothing in flight means the final element has been
      // accepted downstream.
      FLUSH: begin
        if (!inflight && (fifo_cnt == 2'd0)) begin
          state_nxt = CLEAR;
        end
      end

      CLEAR: begin
        clear     = 1'b1;
        state_nxt = DONE;
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy            = (state != IDLE);

  assign bus.col_rd_en   = rd_en;
  assign bus.col_rd_addr = rd_cnt[ADDR_W-1:0];
  assign bus.col_clear   = clear;

  assign bus.out_valid   = (fifo_cnt != 2'd0);
  assign bus.out_data    = fifo_mem[rd_ptr].data;
  assign bus.out_last    = bus.out_valid && fifo_mem[rd_ptr].last;

  // -------------------------------------------------------------------------
  // Structural invariants
  // -------------------------------------------------------------------------
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_cnt == 2'd2)));

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (fifo_cnt == 2'd0)));

  a_read_only_in_read : assert property (@(posedge clk) disable iff (!rst_n)
    !(rd_en && (state != READ)));

endmodule : accum_drain
